// File: rtl/bf8b_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bf8b_pkg
//  Purpose  : Shared types and constants for the bf8b core: the fetch FSM
//             state encoding and the brainfuck opcode byte values.
//  Revision : 1.0  initial release
// ============================================================================
package bf8b_pkg;

    // Fetch engine states: wait for room, hold a request, wait for ready low.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } fetch_state_e;

    // Brainfuck opcode bytes (ASCII encoding of the source characters)
    localparam logic [7:0] OP_INC   = 8'h2B;  // '+'
    localparam logic [7:0] OP_DEC   = 8'h2D;  // '-'
    localparam logic [7:0] OP_RIGHT = 8'h3E;  // '>'
    localparam logic [7:0] OP_LEFT  = 8'h3C;  // '<'
    localparam logic [7:0] OP_OUT   = 8'h2E;  // '.'
    localparam logic [7:0] OP_IN    = 8'h2C;  // ','
    localparam logic [7:0] OP_LOOP  = 8'h5B;  // '['
    localparam logic [7:0] OP_END   = 8'h5D;  // ']'

    // True for any of the eight executable opcode bytes.
    function automatic logic is_bf_opcode(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        case (b)
            OP_INC, OP_DEC, OP_RIGHT, OP_LEFT,
            OP_OUT, OP_IN, OP_LOOP, OP_END: hit = 1'b1;
            default:                        hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Bundles the fetch unit's memory-arbiter client slot, its
//             instruction output port and the redirect input.
//             master = fetch unit side, slave = environment side.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    // Memory arbiter client slot
    logic              mem_request;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_data_out;
    logic              mem_ready;
    logic [7:0]        mem_data_in;

    // Instruction stream towards the executor
    logic              instr_valid;
    logic [7:0]        instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ack;

    // Control-flow redirect
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output mem_request, mem_addr, mem_we, mem_data_out,
        input  mem_ready, mem_data_in,
        output instr_valid, instr, instr_pc,
        input  instr_ack,
        input  redirect, redirect_pc
    );

    modport slave (
        input  mem_request, mem_addr, mem_we, mem_data_out,
        output mem_ready, mem_data_in,
        input  instr_valid, instr, instr_pc,
        output instr_ack,
        output redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Small synchronous prefetch FIFO. Flush beats push/pop; push is
//             dropped when full and pop when empty. DEPTH must be a power
//             of two so the pointers wrap naturally.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);
    localparam int              PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction prefetcher. Issues one read at a time on the
//             lowest-priority arbiter slot, buffers bytes with their PC in
//             fetch_fifo, and restarts on redirect. A transaction in flight
//             at redirect time is allowed to finish; its byte is discarded.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import bf8b_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int                FW        = ADDR_W + 8;
    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_request_q, mem_request_d;
    logic              stale_q, stale_d;
    logic [7:0]        instr_hold_q, instr_hold_d;
    logic [ADDR_W-1:0] pc_hold_q, pc_hold_d;

    logic              capture;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [FW-1:0]     fifo_head;

    // Redirect wins over both push and pop; the flush empties the buffer.
    assign fifo_push = capture && !stale_q && !bus.redirect && !fifo_full;
    assign fifo_pop  = bus.instr_ack && !fifo_empty && !bus.redirect;

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({mem_addr_q, bus.mem_data_in}),
        .pop       (fifo_pop),
        .flush     (bus.redirect),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    // Fetch FSM: next state, request outputs, fetch PC and stale tracking.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        mem_request_d = mem_request_q;
        mem_addr_d    = mem_addr_q;
        stale_d       = stale_q;
        capture       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Only one transaction is ever in flight, so a free slot now
                // is still free when the byte arrives.
                if (!bus.redirect && (fifo_count < DEPTH_CNT)) begin
                    state_d       = ST_REQ;
                    mem_request_d = 1'b1;
                    mem_addr_d    = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (bus.mem_ready) begin
                    capture       = 1'b1;
                    mem_request_d = 1'b0;
                    state_d       = ST_RELEASE;
                    stale_d       = 1'b0;
                    if (!stale_q && !bus.redirect) begin
                        fetch_pc_d = fetch_pc_q + 1'b1;
                    end
                end else if (bus.redirect) begin
                    // Let the handshake finish but throw its data away.
                    stale_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!bus.mem_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                mem_request_d = 1'b0;
            end
        endcase
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
        end
    end

    // Remember the last head so instr/instr_pc hold while the buffer is empty.
    always_comb begin
        instr_hold_d = instr_hold_q;
        pc_hold_d    = pc_hold_q;
        if (!fifo_empty) begin
            instr_hold_d = fifo_head[7:0];
            pc_hold_d    = fifo_head[FW-1:8];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= '0;
            mem_addr_q    <= '0;
            mem_request_q <= 1'b0;
            stale_q       <= 1'b0;
            instr_hold_q  <= '0;
            pc_hold_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_request_q <= mem_request_d;
            stale_q       <= stale_d;
            instr_hold_q  <= instr_hold_d;
            pc_hold_q     <= pc_hold_d;
        end
    end

    assign bus.mem_request  = mem_request_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_we       = 1'b0;
    assign bus.mem_data_out = 8'h00;
    assign bus.instr_valid  = !fifo_empty;
    assign bus.instr        = fifo_empty ? instr_hold_q : fifo_head[7:0];
    assign bus.instr_pc     = fifo_empty ? pc_hold_q    : fifo_head[FW-1:8];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. The reference model is the
//             program order itself: consumed instructions must follow
//             sequential addresses (mod 256) from the last reset/redirect
//             target, each carrying the memory byte at that address.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import bf8b_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(AW)) bus ();

    fetch_unit #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]    mem [256];
    logic [15:0]   exp_q [$];
    logic [AW-1:0] exp_next;
    logic [15:0]   cons_q [$];
    logic [AW-1:0] hs_q [$];
    int            consumed = 0;
    int            hs_count = 0;
    int            stall_min = 0;
    int            stall_max = 0;
    int            stall_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic extend_model(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({exp_next, mem[exp_next]});
            exp_next = exp_next + 1'b1;
        end
    endtask

    task automatic restart_model(input logic [AW-1:0] pc);
        exp_q.delete();
        exp_next = pc;
        extend_model(64);
    endtask

    // Memory/arbiter responder: ready after a random stall, dropped with request.
    always @(posedge clk) begin
        #1;
        if (rst || !bus.mem_request) begin
            bus.mem_ready   = 1'b0;
            bus.mem_data_in = 8'($urandom);
            stall_left      = $urandom_range(stall_max, stall_min);
        end else if (stall_left > 0) begin
            stall_left--;
            bus.mem_ready   = 1'b0;
            bus.mem_data_in = 8'($urandom);
        end else begin
            bus.mem_ready   = 1'b1;
            bus.mem_data_in = mem[bus.mem_addr];
        end
    end

    // Monitor: protocol checks and scoreboard pops, sampled mid-cycle.
    logic          prev_req_wait = 1'b0;
    logic [AW-1:0] prev_addr     = '0;
    logic          prev_redirect = 1'b0;
    logic          hold_ok       = 1'b0;
    logic [7:0]    prev_instr    = '0;
    logic [AW-1:0] prev_pc       = '0;
    logic [15:0]   mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_req_wait = 1'b0;
            prev_redirect = 1'b0;
            hold_ok       = 1'b0;
        end else begin
            check("mem_we", bus.mem_we, 0);
            check("mem_data_out", bus.mem_data_out, 0);
            if (prev_req_wait) begin
                check("req_held", bus.mem_request, 1);
                check("addr_stable", bus.mem_addr, prev_addr);
            end
            if (prev_redirect) begin
                check("valid_after_redirect", bus.instr_valid, 0);
            end
            if (hold_ok && !bus.instr_valid) begin
                check("instr_hold", bus.instr, prev_instr);
                check("pc_hold", bus.instr_pc, prev_pc);
            end
            if (bus.instr_valid && bus.instr_ack && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr_pc", bus.instr_pc, mon_e[15:8]);
                    check("instr", bus.instr, mon_e[7:0]);
                    if (exp_q.size() < 16) extend_model(32);
                end
                cons_q.push_back({bus.instr_pc, bus.instr});
                consumed++;
            end
            if (bus.mem_request && bus.mem_ready) begin
                hs_q.push_back(bus.mem_addr);
                hs_count++;
            end
            prev_req_wait = bus.mem_request && !bus.mem_ready;
            prev_addr     = bus.mem_addr;
            prev_redirect = bus.redirect;
            prev_instr    = bus.instr;
            prev_pc       = bus.instr_pc;
            hold_ok       = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.instr_ack = 1'b0;
        bus.redirect  = 1'b0;
        tick();
        tick();
        check("rst_mem_request", bus.mem_request, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_data_out", bus.mem_data_out, 0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_instr_pc", bus.instr_pc, 0);
        hs_q.delete();
        cons_q.delete();
        hs_count = 0;
        consumed = 0;
        restart_model(8'h00);
        rst = 1'b0;
    endtask

    task automatic wait_consumed(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (consumed < n && c < budget) begin
            tick();
            c++;
        end
        check({name, "_timeout"}, (consumed >= n) ? 1 : 0, 1);
    endtask

    task automatic issue_redirect(input logic [AW-1:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        restart_model(pc);
        tick();
        bus.redirect = 1'b0;
    endtask

    logic [7:0] ops [8];

    initial begin
        int c;
        logic [AW-1:0] rpc;
        bus.instr_ack   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        ops = '{OP_INC, OP_DEC, OP_RIGHT, OP_LEFT, OP_OUT, OP_IN, OP_LOOP, OP_END};
        for (int i = 0; i < 256; i++) mem[i] = ops[$urandom_range(0, 7)];
        mem[0] = OP_INC;
        mem[1] = OP_RIGHT;
        mem[2] = OP_LOOP;
        mem[3] = OP_END;

        // Straight-line fetch from reset with a consumer that always accepts.
        stall_min = 0; stall_max = 0;
        do_reset();
        bus.instr_ack = 1'b1;
        wait_consumed(4, 80, "seq4");
        check("seq_pc0", cons_q[0][15:8], 8'h00);
        check("seq_pc3", cons_q[3][15:8], 8'h03);
        check("seq_b0", cons_q[0][7:0], 8'h2B);
        check("seq_b1", cons_q[1][7:0], 8'h3E);
        check("seq_b2", cons_q[2][7:0], 8'h5B);
        check("seq_b3", cons_q[3][7:0], 8'h5D);

        // Stalled consumer: buffer fills, then exactly one refill after one pop.
        stall_min = 1; stall_max = 1;
        do_reset();
        repeat (40) tick();
        check("full_hs_count", hs_count, 4);
        check("full_no_request", bus.mem_request, 0);
        check("full_valid", bus.instr_valid, 1);
        bus.instr_ack = 1'b1;
        tick();
        bus.instr_ack = 1'b0;
        repeat (30) tick();
        check("refill_hs_count", hs_count, 5);
        check("refill_addr", hs_q[4], 8'h04);
        check("refill_no_request", bus.mem_request, 0);

        // Redirect while a slow request at 0x05 is pending.
        stall_min = 6; stall_max = 6;
        do_reset();
        issue_redirect(8'h05);
        c = 0;
        while (!(bus.mem_request && bus.mem_addr == 8'h05) && c < 20) begin
            tick();
            c++;
        end
        check("req_at_05_seen", (bus.mem_request && bus.mem_addr == 8'h05) ? 1 : 0, 1);
        issue_redirect(8'h10);
        bus.instr_ack = 1'b1;
        wait_consumed(2, 120, "stale");
        check("stale_hs0", hs_q[0], 8'h05);
        check("stale_hs1", hs_q[1], 8'h10);
        check("stale_first_pc", cons_q[0][15:8], 8'h10);

        // Address wrap at the top of memory.
        stall_min = 0; stall_max = 2;
        do_reset();
        bus.instr_ack = 1'b1;
        issue_redirect(8'hFE);
        cons_q.delete();
        c = consumed;
        wait_consumed(c + 3, 80, "wrap");
        check("wrap_pc0", cons_q[0][15:8], 8'hFE);
        check("wrap_pc1", cons_q[1][15:8], 8'hFF);
        check("wrap_pc2", cons_q[2][15:8], 8'h00);

        // Reset in the release phase.
        stall_min = 0; stall_max = 0;
        do_reset();
        c = 0;
        while (!(bus.mem_request && bus.mem_ready) && c < 20) begin
            tick();
            c++;
        end
        check("hs_before_rst", (bus.mem_request && bus.mem_ready) ? 1 : 0, 1);
        tick();
        rst = 1'b1;
        tick();
        check("rst_rel_request", bus.mem_request, 0);
        check("rst_rel_valid", bus.instr_valid, 0);
        rst = 1'b0;
        hs_q.delete();
        restart_model(8'h00);
        c = 0;
        while (hs_q.size() == 0 && c < 20) begin
            tick();
            c++;
        end
        check("rst_restart_addr", (hs_q.size() > 0) ? 32'(hs_q[0]) : 32'hDEAD, 8'h00);

        // Randomized traffic: stalls, back-pressure and redirects.
        stall_min = 0; stall_max = 4;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.instr_ack = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                rpc = 8'($urandom);
                bus.redirect    = 1'b1;
                bus.redirect_pc = rpc;
                restart_model(rpc);
            end else begin
                bus.redirect = 1'b0;
            end
            tick();
        end
        bus.redirect  = 1'b0;
        bus.instr_ack = 1'b0;
        tick();
        check("random_progress", (consumed > 200) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of prefetch buffer entries (power of two, >=2).
REQ-002 Parameter ADDR_W, default 8, program-counter and memory address width.
REQ-003 clk  input  1  the one clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 mem_request  output  1  memory-arbiter request, this unit's client slot.
REQ-006 mem_addr  output  ADDR_W  fetch address presented with mem_request.
REQ-007 mem_we  output  1  write enable, tied 0 (fetch is read-only).
REQ-008 mem_data_out  output  8  write data, tied 0.
REQ-009 mem_ready  input  1  arbiter ready for this client slot.
REQ-010 mem_data_in  input  8  memory read data, valid while mem_ready=1.
REQ-011 instr_valid  output  1  FIFO head holds a valid instruction.
REQ-012 instr  output  8  instruction byte at FIFO head.
REQ-013 instr_pc  output  ADDR_W  address the head instruction was fetched from.
REQ-014 instr_ack  input  1  consumer pops head this cycle; ignored when instr_valid=0.
REQ-015 redirect  input  1  one-cycle pulse: flush and restart fetch (loop jump).
REQ-016 redirect_pc  input  ADDR_W  new fetch address, sampled when redirect=1.

Function
REQ-017 FSM states: IDLE, REQ, RELEASE.
REQ-018 IDLE->REQ when (count + 0) < FIFO_DEPTH and redirect=0; mem_request=1 and mem_addr=fetch_pc from the next cycle.
REQ-019 In REQ, mem_request and mem_addr are held stable until mem_ready=1.
REQ-020 In REQ with mem_ready=1: capture mem_data_in, drop mem_request next cycle, go RELEASE.
REQ-021 Captured byte is pushed into the FIFO with its address in the capture cycle unless the transaction is marked stale.
REQ-022 fetch_pc increments by 1 per non-stale capture, wrapping 0xFF->0x00 modulo 2^ADDR_W.
REQ-023 RELEASE->IDLE when mem_ready=0; mem_request is never reasserted while mem_ready=1.
REQ-024 At most one memory transaction is outstanding; a slot is reserved, so REQ is entered only if the FIFO will have room on capture.
REQ-025 FIFO full: no new request; instr_valid stays 1; pending capture cannot occur (guaranteed by REQ-024).
REQ-026 FIFO empty: instr_valid=0; instr and instr_pc hold last values.
REQ-027 Simultaneous push and pop: count unchanged, both take effect; a push into an empty FIFO becomes visible on instr_valid the following cycle.
REQ-028 redirect in IDLE: FIFO cleared, fetch_pc<=redirect_pc, no request that cycle.
REQ-029 redirect in REQ or RELEASE: FIFO cleared, fetch_pc<=redirect_pc, transaction is completed per handshake (never aborted), its data marked stale and discarded.
REQ-030 redirect takes priority over instr_ack and push in the same cycle; instr_valid=0 the cycle after redirect.
REQ-031 Second redirect while stale transaction pending: latest redirect_pc wins, stale flag remains.
REQ-032 Best-case throughput: one instruction per 4 cycles (IDLE, REQ, ready, RELEASE).

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, fetch_pc=0, FIFO count=0, read/write pointers=0, stale=0.
REQ-034 Reset outputs: mem_request=0, mem_addr=0, mem_we=0, mem_data_out=0, instr_valid=0, instr=0, instr_pc=0.
REQ-035 Reset mid-transaction drops mem_request immediately; the arbiter is reset by the same rst.

Structure
REQ-036 FSM state encodings and the brainfuck opcode byte constants live in the shared package bf8b_pkg.
REQ-037 The prefetch buffer is a sub-module fetch_fifo (params WIDTH, DEPTH; push, pop, flush, full, empty, count).
REQ-038 The unit connects to the arbiter's client slot 0 (lowest priority); exec holds the higher slot.

Verification
REQ-039 Reset, memory 0x00..0x03 = '+','>','[',']', instr_ack=1 always -> instrs '+','>','[',']' with instr_pc 0,1,2,3, mem_we never 1.
REQ-040 instr_ack=0, DEPTH=4 -> exactly 4 transactions, count=4, mem_request stays 0 until one ack, then one more fetch at addr 4.
REQ-041 redirect, redirect_pc=0x10 during REQ at addr 0x05 -> handshake completes, byte from 0x05 discarded, next instr_pc=0x10.
REQ-042 fetch_pc=0xFF -> fetch at 0xFF then 0x00, instr_pc sequence 0xFF,0x00.
REQ-043 Arbiter ready delayed 5 cycles by higher-priority exec client -> mem_addr stable, single push, no duplicate request.
REQ-044 rst asserted in RELEASE -> next cycle mem_request=0, instr_valid=0, fetch restarts at addr 0.
